// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and sizes for the two-master split-capable bus arbiter.
// Optional feature macro: BUS_ARB_RR_EN (round-robin instead of fixed priority).
package bus_pkg;

    localparam int NUM_MASTERS     = 2;
    localparam int NUM_SLAVES      = 3;
    localparam int ARB_GNT_TIMEOUT = 16;
    localparam int SLV_W           = $clog2(NUM_SLAVES);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    // The one parked transaction: who owns it and which slave will release it.
    typedef struct packed {
        logic             pending;
        logic [1:0]       owner;
        logic [SLV_W-1:0] slave;
    } split_rec_t;

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Arbiter-facing bundle of request, frame, split and grant signals.
// Optional feature macro: BUS_ARB_RR_EN (does not change this interface).
//
// Handshake: req_i is a level held by a master until it is served. A grant
// (gnt_o, one-hot) is held from the cycle after arbitration until either the
// frame that frame_active_i marks has ended, the master withdraws before the
// frame starts, or the grant times out (gnt_timeout_o pulses). split_req_i is
// a single-cycle pulse qualified by split_slave_i; split_ready_i is a level.
interface split_bus_arbiter_if;
    import bus_pkg::*;

    logic [NUM_MASTERS-1:0] req_i;
    logic                   frame_active_i;
    logic                   split_req_i;
    logic [SLV_W-1:0]       split_slave_i;
    logic [NUM_SLAVES-1:0]  split_ready_i;
    logic [NUM_MASTERS-1:0] gnt_o;
    logic                   msel_o;
    logic                   split_pending_o;
    logic [NUM_MASTERS-1:0] split_owner_o;
    logic                   gnt_timeout_o;

    modport slave (
        input  req_i, frame_active_i, split_req_i, split_slave_i, split_ready_i,
        output gnt_o, msel_o, split_pending_o, split_owner_o, gnt_timeout_o
    );

    modport master (
        output req_i, frame_active_i, split_req_i, split_slave_i, split_ready_i,
        input  gnt_o, msel_o, split_pending_o, split_owner_o, gnt_timeout_o
    );

endinterface

// File: rtl/split_bus_arbiter_pick.sv
// Combinational 2-way winner pick from an eligible mask.
// BUS_ARB_RR_EN defined: round-robin starting at ptr; undefined: master 0 first.
module arb_rr_pick (
    input  logic [1:0] eligible,
`ifdef BUS_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] winner
);

    // One-hot winner, or zero when nobody is eligible.
    always_comb begin
        winner = 2'b00;
`ifdef BUS_ARB_RR_EN
        if (eligible[ptr]) begin
            winner[ptr] = 1'b1;
        end else if (eligible[~ptr]) begin
            winner[~ptr] = 1'b1;
        end
`else
        if (eligible[0]) begin
            winner = 2'b01;
        end else if (eligible[1]) begin
            winner = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter holding ownership for a full serial frame, with a
// single parked (split) transaction that resumes ahead of normal arbitration.
// Optional feature macro: BUS_ARB_RR_EN (round-robin pointer; else fixed priority).
module split_bus_arbiter
    import bus_pkg::*;
#(
    parameter int GNT_TIMEOUT = ARB_GNT_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    split_bus_arbiter_if.slave  bus,
    output arb_state_e          dbg_state_o
);

    localparam int TO_W = $clog2(GNT_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               msel_q, msel_d;
    logic               tmo_q, tmo_d;
    split_rec_t         split_q, split_d;
    logic [TO_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [(1<<SLV_W)-1:0] ready_pad;
    logic               parked_ready;
    logic [1:0]         blocked, eligible, pick_win, winner;
    logic               resume;
`ifdef BUS_ARB_RR_EN
    logic               ptr_q, ptr_d;
`endif

    // Ready of the parked slave; the padded vector keeps every index in range.
    always_comb begin
        ready_pad = '0;
        ready_pad[NUM_SLAVES-1:0] = bus.split_ready_i;
        parked_ready = ready_pad[split_q.slave];
        blocked  = (split_q.pending && !parked_ready) ? split_q.owner : 2'b00;
        eligible = bus.req_i & ~blocked;
        resume   = split_q.pending && parked_ready && |(bus.req_i & split_q.owner);
        winner   = resume ? split_q.owner : pick_win;
    end

    arb_rr_pick u_pick (
        .eligible (eligible),
`ifdef BUS_ARB_RR_EN
        .ptr      (ptr_q),
`endif
        .winner   (pick_win)
    );

    // Next-state and next-output decode; everything holds unless an event fires.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        msel_d  = msel_q;
        tmo_d   = 1'b0;
        split_d = split_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
`ifdef BUS_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|eligible) begin
                    state_d = ARB_GRANT;
                    gnt_d   = winner;
                    msel_d  = winner[1];
                    cnt_d   = '0;
                    if (resume) begin
                        split_d = '0;
                    end
                end
            end
            ARB_GRANT: begin
                if (bus.frame_active_i) begin
                    state_d = ARB_BUSY;
                    cnt_d   = '0;
                end else if (!bus.req_i[msel_q]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = 2'b00;
                end else if (cnt_inc == TO_W'(GNT_TIMEOUT)) begin
                    state_d = ARB_IDLE;
                    gnt_d   = 2'b00;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
`ifdef BUS_ARB_RR_EN
                    ptr_d   = ~msel_q;
`endif
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ARB_BUSY: begin
                if (bus.split_req_i && !split_q.pending) begin
                    split_d.pending = 1'b1;
                    split_d.owner   = gnt_q;
                    split_d.slave   = bus.split_slave_i;
                end
                if (!bus.frame_active_i) begin
                    state_d = ARB_IDLE;
                    gnt_d   = 2'b00;
`ifdef BUS_ARB_RR_EN
                    ptr_d   = ~msel_q;
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered grant, mux select, split record, timeout counter and pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q   <= 2'b00;
            msel_q  <= 1'b0;
            tmo_q   <= 1'b0;
            split_q <= '0;
            cnt_q   <= '0;
`ifdef BUS_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            gnt_q   <= gnt_d;
            msel_q  <= msel_d;
            tmo_q   <= tmo_d;
            split_q <= split_d;
            cnt_q   <= cnt_d;
`ifdef BUS_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.gnt_o           = gnt_q;
    assign bus.msel_o          = msel_q;
    assign bus.split_pending_o = split_q.pending;
    assign bus.split_owner_o   = split_q.owner;
    assign bus.gnt_timeout_o   = tmo_q;
    assign dbg_state_o         = state_q;

endmodule

// File: doc/split_bus_arbiter.md
Name: split_bus_arbiter

Overview:
- Two-master arbiter/scheduler for the shared bit-serial request link (p2s mux -> s2p -> addr_decoder -> slave_mem).
- Issues one-hot grants, drives the master-select mux, and holds ownership for a whole serial frame.
- Tracks split transactions: a slave parks a master's transaction, the bus is released to the other master, and the parked master is re-granted with priority when the slave signals completion.

Parameters:
- NUM_MASTERS, 2 (bus_pkg), number of requesters; the RTL supports exactly 2.
- NUM_SLAVES, 3 (bus_pkg), number of slaves able to issue split.
- GNT_TIMEOUT, 16, cycles a grant may wait for frame start before it is revoked.
- TO_W, $clog2(GNT_TIMEOUT+1), width of the timeout counter (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  2  per-master request, level, held until served
- frame_active_i  in  1  OR of master svalid; high for the duration of a serial frame
- split_req_i  in  1  single-cycle pulse from the slave side: park the current transaction
- split_slave_i  in  $clog2(NUM_SLAVES)  index of the slave issuing the split; valid with split_req_i
- split_ready_i  in  NUM_SLAVES  per-slave level: parked transaction is ready to resume
- gnt_o  out  2  one-hot grant
- msel_o  out  1  mux select, 1 = master 1
- split_pending_o  out  1  a parked transaction exists
- split_owner_o  out  2  one-hot owner of the parked transaction; 0 when none
- gnt_timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; RR pointer -> master 0; timeout counter 0.
- Eligible set: req_i & ~blocked. `blocked` = split_owner_o while split_pending_o is set and split_ready_i[parked slave] is low.
- State IDLE:
  - If the eligible set is non-empty, pick a winner and go to GRANT next cycle.
  - gnt_o and msel_o are registered, so the grant appears 1 cycle after the request is seen in IDLE.
  - Winner selection, in order:
    - (a) the split owner, if split is pending, its slave is ready, and it requests (resume priority);
    - (b) otherwise the arbitration policy (see Optional Feature).
  - On an (a) grant: clear split_pending_o and split_owner_o in the same edge.
- State GRANT:
  - gnt_o and msel_o are held; the timeout counter increments each cycle.
  - frame_active_i=1 -> BUSY and clear the counter.
  - req_i[winner] drops before the frame starts -> IDLE, gnt_o=0, no pointer update.
  - Counter reaches GNT_TIMEOUT -> IDLE, gnt_o=0, pulse gnt_timeout_o, and advance the RR pointer past the winner.
- State BUSY:
  - gnt_o is held.
  - frame_active_i falls -> IDLE, gnt_o=0, and the RR pointer moves to the other master.
  - split_req_i=1 in BUSY: latch split_pending_o=1, split_owner_o=gnt_o, and the parked slave index. The frame still completes normally.
  - split_req_i outside BUSY is ignored.
- msel_o keeps the last granted master while IDLE; it never glitches mid-frame.
- A second split_req_i while a split is already pending is ignored; only one split is tracked.
- Simultaneous events:
  - Frame end and a new request in the same cycle: the request is arbitrated in the following IDLE cycle.
  - The split owner dropping req_i while pending keeps it parked; the pending state clears only on the resume grant.
- Invariants: gnt_o is at most one-hot. gnt_o is never asserted to a blocked master.
- Reset asserted mid-frame: everything clears immediately, including the split record.

Optional Feature:
- Macro: BUS_ARB_RR_EN.
- Defined: round-robin among eligible masters, starting from the RR pointer.
- Undefined: fixed priority, master 0 over master 1. The RR pointer logic is removed and no pointer updates occur.
- Split resume priority and timeout behave identically in both builds.

Decomposition:
- bus_pkg owns:
  - NUM_MASTERS, NUM_SLAVES;
  - typedef arb_state_e {ARB_IDLE, ARB_GRANT, ARB_BUSY};
  - typedef split_rec_t {pending, owner[1:0], slave idx};
  - ARB_GNT_TIMEOUT default.
- One natural sub-module: arb_rr_pick, a combinational 2-way winner pick from an eligible mask and pointer, fixed-priority variant under the macro. Everything else stays in split_bus_arbiter.

Test Plan:
- req_i=01 -> gnt_o=01 one cycle later, msel_o=0; frame_active_i held 20 cycles then low -> gnt_o=00 on the next edge.
- req_i=11 held with back-to-back frames (RR build) -> grants alternate 01,10,01; fixed build -> 01 repeatedly.
- Master 0 in BUSY, split_req_i pulse with split_slave_i=2 -> split_pending_o=1, split_owner_o=01. With req_i=11 and split_ready_i[2]=0, only master 1 is granted. Raise split_ready_i[2]=1 -> master 0 is granted next, ahead of RR, and split_pending_o falls.
- Grant issued, frame_active_i kept low for 16 cycles -> gnt_o=00 and gnt_timeout_o pulses once at cycle 16. Other master requesting -> it wins next.
- rst_ni low mid-BUSY with a split pending -> all outputs 0 asynchronously. After release, req_i=10 -> gnt_o=10 with no blocking.
